// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer of link addresses pushed by JAL and popped on return.
// The popped address is registered; the top entry is also exposed combinationally.
module return_addr_stack #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int unsigned CntW = PTR_W + 1;

  typedef enum logic [0:0] {StIdle, StRet} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d, sp_m1;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              is_empty, is_full, pop_ok;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] top_entry;

  assign sp_m1     = sp_q - PTR_W'(1);
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CntW'(DEPTH));
  assign top_entry = mem[sp_m1];
  // A pop is accepted when there is something to return, or a push can be bypassed.
  assign pop_ok    = pop & (~is_empty | push);

  always_comb begin
    sp_d       = sp_q;
    count_d    = count_q;
    ret_addr_d = ret_addr_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    mem_we     = 1'b0;
    mem_waddr  = sp_q;
    // Clear first so a same-cycle error event below wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    case ({push, pop})
      2'b10: begin
        mem_we    = 1'b1;
        mem_waddr = sp_q;
        sp_d      = sp_q + PTR_W'(1);
        if (is_full) ovf_d = 1'b1;
        else         count_d = count_q + CntW'(1);
      end
      2'b01: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          ret_addr_d = top_entry;
          sp_d       = sp_m1;
          count_d    = count_q - CntW'(1);
        end
      end
      2'b11: begin
        if (is_empty) begin
          ret_addr_d = push_addr;
        end else begin
          ret_addr_d = top_entry;
          mem_we     = 1'b1;
          mem_waddr  = sp_m1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q       <= '0;
      count_q    <= '0;
      ret_addr_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      count_q    <= count_d;
      ret_addr_q <= ret_addr_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= push_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = pop_ok ? StRet : StIdle;
      StRet:   state_d = pop_ok ? StRet : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ret_valid = (state_q == StRet);
  end

  assign ret_addr = ret_addr_q;
  assign top_addr = is_empty ? '0 : top_entry;
  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule
